rr_grant_arb4: RTL
==================

// Module: rr_grant_arb4
// PURPOSE
//  4-requester round-robin arbiter with grant locking and a hold timeout.
//  Drives the one-hot grant lines gnt0..gnt3 into the one-hot checker (s0..s3).
//  The checker's output must equal gnt_valid in every cycle.
//  Grants are registered. Owners keep the grant while requesting, up to MAX_HOLD
//  cycles; after that a waiting requester preempts the owner.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles before preemption (legal range 2..256)
//  CNT_W     $clog2(MAX_HOLD)  width of hold counter (derived, do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      async active-low reset
//  req        in   4      request per requester; bit i = requester i
//  gnt0..gnt3 out  1 each registered grant; at most one high
//  gnt_valid  out  1      OR of gnt0..gnt3
//  gnt_id     out  2      index of current owner; 0 when gnt_valid=0
//  preempt    out  1      1-cycle pulse on the edge where a timeout forces handover
// BEHAVIOUR
//  Reset (rst_n=0, async): all gnt*=0, gnt_valid=0, gnt_id=0, preempt=0.
//   Also: state=IDLE, ptr=0, hold_cnt=0. Outputs clear immediately, not at the next edge.
//  ptr: highest-priority index. Search order is ptr, ptr+1, ... (mod 4).
//   On every new grant to winner w, ptr <= w+1 mod 4 (3 wraps to 0).
//  pick(mask): first set bit of mask in search order from ptr; none -> no winner.
//  State IDLE (no owner):
//   req==0 -> stay IDLE.
//   req!=0 -> GRANT to pick(req). gnt visible 1 cycle after req is sampled.
//   hold_cnt <= 0.
//  State GRANT (owner o):
//   (a) req[o]=1 and hold_cnt<MAX_HOLD-1 -> keep o, hold_cnt++.
//   (b) req[o]=0 -> release. If pick(req) exists, grant it on the same edge
//       (direct handover, no idle gap, hold_cnt<=0). Otherwise go to IDLE.
//   (c) req[o]=1 and hold_cnt==MAX_HOLD-1:
//       - others = req & ~onehot(o) nonzero -> grant pick(others), preempt=1 that cycle,
//         hold_cnt<=0.
//       - others==0 -> keep o, hold_cnt<=0, no preempt.
//  Handover changes gnt from one-hot(o) to one-hot(new) in one edge. Never 2 bits high.
//  Owner's req falling and its timeout in the same cycle -> rule (b); preempt stays 0.
//  A requester dropping req before being granted is simply not picked (no memory of it).
//  Winner selection always uses req sampled in the same cycle.
//  Reset mid-grant: outputs clear at once. After release, arbitration restarts from ptr=0.
//  All outputs registered; no combinational path from req to gnt*.
// TESTING
//  1 Reset, then req=4'b0001 -> next edge gnt0=1, gnt_id=0, gnt_valid=1.
//  2 MAX_HOLD=4, req=4'b1111 held -> owner sequence 0,1,2,3,0.
//    Each owner holds 4 cycles. preempt pulses at each switch.
//  3 Owner 1 drops req while req[3]=1 -> next edge gnt3=1, gnt1=0, gnt_valid never 0.
//  4 Only req[2]=1 for 20 cycles, MAX_HOLD=4 -> gnt2 held for all 20 cycles, preempt stays 0.
//  5 rst_n=0 for 1 cycle mid-grant of requester 2 -> gnt* drop before the next clk.
//    Then req=4'b1100 -> gnt2 (ptr restarted at 0).
//  6 Random req, 10k cycles -> checker(gnt0..3) == gnt_valid every cycle.
//    popcount(gnt) <= 1 every cycle. Every held request granted within 3*MAX_HOLD+1 cycles.

Source files
------------

// File: rtl/rr_grant_arb4.sv
// rr_grant_arb4: four-requester round-robin arbiter with grant locking.
// The current owner keeps its grant while it keeps requesting, for up to
// MAX_HOLD consecutive cycles. After that, any other waiting requester takes
// over on the next edge and preempt pulses for one cycle. Every output comes
// straight from a flop, so there is no combinational path from req to a grant.
module rr_grant_arb4 #(
  parameter  int MAX_HOLD = 8,
  localparam int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       gnt0,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Hold counter value on the owner's last allowed cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;          // highest-priority index for the next pick
  logic [CNT_W-1:0] hold_cnt, hold_nxt;    // cycles the owner has held, minus one
  logic [3:0]       gnt_q, gnt_nxt;        // one-hot grant register
  logic [1:0]       id_q, id_nxt;          // owner index, 0 while nobody owns
  logic             valid_q, valid_nxt;
  logic             preempt_q, preempt_nxt;

  logic [3:0]       others;                // requests from everyone except the owner
  logic [2:0]       pick_all, pick_oth;    // {found, index}
  logic             do_grant;
  logic [1:0]       winner;

  // The first set bit of mask, searching base, base+1, ... modulo 4.
  // The loop runs from the farthest offset down to the nearest one, so the
  // nearest set bit is the last to write res and wins.
  function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign others   = req & ~(4'b0001 << id_q);
  assign pick_all = pick(req, ptr);
  assign pick_oth = pick(others, ptr);

  // Next-state, next-grant and pointer/counter update for IDLE and GRANT.
  always_comb begin
    // NOTE: every variable gets a default before the case. A path that skips
    // an assignment would otherwise infer a latch.
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt_q;
    id_nxt      = id_q;
    preempt_nxt = 1'b0;
    do_grant    = 1'b0;
    winner      = 2'd0;

    unique case (state)
      IDLE: begin
        hold_nxt = '0;
        if (pick_all[2]) begin
          do_grant = 1'b1;
          winner   = pick_all[1:0];
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          // The owner released. Hand over directly if someone is waiting.
          if (pick_all[2]) begin
            do_grant = 1'b1;
            winner   = pick_all[1:0];
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            id_nxt    = 2'd0;
            hold_nxt  = '0;
          end
        end else if (hold_cnt < HOLD_LAST) begin
          hold_nxt = hold_cnt + 1'b1;
        end else if (pick_oth[2]) begin
          // The hold time has run out and another requester is waiting.
          do_grant    = 1'b1;
          winner      = pick_oth[1:0];
          preempt_nxt = 1'b1;
        end else begin
          // The hold time has run out, but nobody else is asking.
          hold_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        id_nxt    = 2'd0;
        hold_nxt  = '0;
      end
    endcase

    if (do_grant) begin
      state_nxt = GRANT;
      gnt_nxt   = 4'b0001 << winner;
      id_nxt    = winner;
      ptr_nxt   = winner + 2'd1;
      hold_nxt  = '0;
    end

    valid_nxt = |gnt_nxt;
  end

  // State, pointer, counter and output registers; all clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      gnt_q     <= 4'b0000;
      id_q      <= 2'd0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // values from before this edge, whatever order the statements are in.
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt_q     <= gnt_nxt;
      id_q      <= id_nxt;
      valid_q   <= valid_nxt;
      preempt_q <= preempt_nxt;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign gnt2      = gnt_q[2];
  assign gnt3      = gnt_q[3];
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;
  assign preempt   = preempt_q;

endmodule
